// File: rtl/riscv_decode_queue.sv
// RV32 control decoder feeding a DEPTH-entry FIFO of decoded entries, with
// illegal-instruction detection, a trap lock held until acknowledged, and a flush.
module riscv_decode_queue #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  in_instr,
    input  logic [XLEN-1:0]              in_pc,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [31:0]                  out_instr,
    output logic [XLEN-1:0]              out_pc,
    output logic [21:0]                  out_ctrl,
    input  logic                         flush,
    input  logic                         trap_ack,
    output logic                         trap_pending,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam int B_ALU_SRC    = 4;
    localparam int B_REG_WRITE  = 5;
    localparam int B_MEM_TO_REG = 6;
    localparam int B_MEM_WRITE  = 7;
    localparam int B_BEQ        = 8;
    localparam int B_BNE        = 9;
    localparam int B_BLTU       = 10;
    localparam int B_JAL        = 11;
    localparam int B_JALR       = 12;
    localparam int B_LB         = 13;
    localparam int B_S_TYPE     = 14;
    localparam int B_CSRRSI     = 15;
    localparam int B_CSRRCI     = 16;
    localparam int B_ECALL      = 17;
    localparam int B_URET       = 18;
    localparam int B_ILLEGAL    = 19;
    localparam int B_RS1_USED   = 20;
    localparam int B_RS2_USED   = 21;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_legal;
    logic [21:0] w_raw;
    logic [21:0] w_ctrl;
    logic        w_is_trap;
    logic        w_push;
    logic        w_pop;

    logic [31:0]     r_instr_mem [DEPTH];
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [21:0]     r_ctrl_mem  [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            r_lock;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_funct7 = in_instr[31:25];

    always_comb begin
        w_legal = 1'b0;
        w_raw   = '0;
        case (w_opcode)
            OPC_OP: begin
                w_legal = (w_funct7 == 7'b0000000) ||
                          (w_funct7 == 7'b0100000 && (w_funct3 == 3'b000 || w_funct3 == 3'b101));
                w_raw[3:0]          = {in_instr[30], w_funct3};
                w_raw[B_REG_WRITE]  = 1'b1;
                w_raw[B_RS1_USED]   = 1'b1;
                w_raw[B_RS2_USED]   = 1'b1;
            end
            OPC_OP_IMM: begin
                // Shift-immediates constrain funct7; the rest carry immediate bits there.
                if (w_funct3 == 3'b001)
                    w_legal = (w_funct7 == 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_legal = (w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000);
                else
                    w_legal = 1'b1;
                w_raw[3:0]          = {(w_funct3 == 3'b101) & in_instr[30], w_funct3};
                w_raw[B_ALU_SRC]    = 1'b1;
                w_raw[B_REG_WRITE]  = 1'b1;
                w_raw[B_RS1_USED]   = 1'b1;
            end
            OPC_LOAD: begin
                w_legal             = (w_funct3 == 3'b000) || (w_funct3 == 3'b010);
                w_raw[B_LB]         = (w_funct3 == 3'b000);
                w_raw[B_ALU_SRC]    = 1'b1;
                w_raw[B_REG_WRITE]  = 1'b1;
                w_raw[B_MEM_TO_REG] = 1'b1;
                w_raw[B_RS1_USED]   = 1'b1;
            end
            OPC_STORE: begin
                w_legal             = (w_funct3 == 3'b010);
                w_raw[B_ALU_SRC]    = 1'b1;
                w_raw[B_MEM_WRITE]  = 1'b1;
                w_raw[B_S_TYPE]     = 1'b1;
                w_raw[B_RS1_USED]   = 1'b1;
                w_raw[B_RS2_USED]   = 1'b1;
            end
            OPC_BRANCH: begin
                w_legal             = (w_funct3 == 3'b000) || (w_funct3 == 3'b001) || (w_funct3 == 3'b110);
                w_raw[3:0]          = (w_funct3 == 3'b110) ? 4'b0011 : 4'b1000;
                w_raw[B_BEQ]        = (w_funct3 == 3'b000);
                w_raw[B_BNE]        = (w_funct3 == 3'b001);
                w_raw[B_BLTU]       = (w_funct3 == 3'b110);
                w_raw[B_RS1_USED]   = 1'b1;
                w_raw[B_RS2_USED]   = 1'b1;
            end
            OPC_JAL: begin
                w_legal             = 1'b1;
                w_raw[B_JAL]        = 1'b1;
                w_raw[B_REG_WRITE]  = 1'b1;
            end
            OPC_JALR: begin
                w_legal             = (w_funct3 == 3'b000);
                w_raw[B_JALR]       = 1'b1;
                w_raw[B_ALU_SRC]    = 1'b1;
                w_raw[B_REG_WRITE]  = 1'b1;
                w_raw[B_RS1_USED]   = 1'b1;
            end
            OPC_LUI: begin
                w_legal             = 1'b1;
                w_raw[B_ALU_SRC]    = 1'b1;
                w_raw[B_REG_WRITE]  = 1'b1;
            end
            OPC_SYSTEM: begin
                if (w_funct3 == 3'b000) begin
                    if (in_instr[31:7] == 25'd0) begin
                        w_legal        = 1'b1;
                        w_raw[B_ECALL] = 1'b1;
                    end else if (in_instr[31:20] == 12'h002 && in_instr[19:7] == 13'd0) begin
                        w_legal        = 1'b1;
                        w_raw[B_URET]  = 1'b1;
                    end
                end else if (w_funct3 == 3'b110) begin
                    w_legal             = 1'b1;
                    w_raw[B_CSRRSI]     = 1'b1;
                    w_raw[B_REG_WRITE]  = 1'b1;
                end else if (w_funct3 == 3'b111) begin
                    w_legal             = 1'b1;
                    w_raw[B_CSRRCI]     = 1'b1;
                    w_raw[B_REG_WRITE]  = 1'b1;
                end
            end
            default: w_legal = 1'b0;
        endcase
        w_ctrl = w_legal ? w_raw : (22'd1 << B_ILLEGAL);
    end

    assign w_is_trap = w_ctrl[B_ECALL] | w_ctrl[B_URET] | w_ctrl[B_ILLEGAL];

    assign out_valid    = (r_count != '0);
    assign in_ready     = !r_lock && !flush && ((r_count < CW'(DEPTH)) || out_ready);
    assign w_push       = in_valid && in_ready;
    assign w_pop        = out_valid && out_ready;
    assign count        = r_count;
    assign trap_pending = r_lock;

    assign out_instr = out_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign out_pc    = out_valid ? r_pc_mem[r_rd_ptr]    : '0;
    assign out_ctrl  = out_valid ? r_ctrl_mem[r_rd_ptr]  : '0;

    // NOTE: the entry storage has no reset; r_count gates what reaches the outputs,
    // so stale contents are never visible and the arrays can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_ctrl_mem[r_wr_ptr]  <= w_ctrl;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_lock   <= 1'b0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_lock   <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_push)
                r_count <= r_count - CW'(1);
            // A trap accepted this cycle wins over a concurrent acknowledge.
            if (w_push && w_is_trap)
                r_lock <= 1'b1;
            else if (trap_ack)
                r_lock <= 1'b0;
        end
    end

endmodule

// File: tb/tb_riscv_decode_queue.sv
// Directed and randomized bench for riscv_decode_queue against a queue-based
// reference model with its own table-style decoder.
module tb_riscv_decode_queue;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [XLEN-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [XLEN-1:0]   out_pc;
    logic [21:0]       out_ctrl;
    logic              flush;
    logic              trap_ack;
    logic              trap_pending;
    logic [$clog2(DEPTH+1)-1:0] count;

    riscv_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_ctrl     (out_ctrl),
        .flush        (flush),
        .trap_ack     (trap_ack),
        .trap_pending (trap_pending),
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [21:0]     ctrl;
    } entry_t;

    entry_t m_q[$];
    bit     m_lock;
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decoder written straight from the instruction rules.
    function automatic logic [21:0] ref_decode(input logic [31:0] w);
        logic [21:0] c;
        bit          ok;
        int          op, f3, f7;
        op = int'(w[6:0]);
        f3 = int'(w[14:12]);
        f7 = int'(w[31:25]);
        c  = '0;
        ok = 0;
        case (op)
            'h33: begin
                ok = (f7 == 0) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
                c[3:0] = {w[30], w[14:12]};
                c[5] = 1; c[20] = 1; c[21] = 1;
            end
            'h13: begin
                ok = !(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 'h20);
                c[3:0] = {(f3 == 5) && w[30], w[14:12]};
                c[4] = 1; c[5] = 1; c[20] = 1;
            end
            'h03: begin
                ok = (f3 == 0) || (f3 == 2);
                c[13] = (f3 == 0);
                c[4] = 1; c[5] = 1; c[6] = 1; c[20] = 1;
            end
            'h23: begin
                ok = (f3 == 2);
                c[4] = 1; c[7] = 1; c[14] = 1; c[20] = 1; c[21] = 1;
            end
            'h63: begin
                ok = (f3 == 0) || (f3 == 1) || (f3 == 6);
                c[3:0] = (f3 == 6) ? 4'd3 : 4'd8;
                c[8] = (f3 == 0); c[9] = (f3 == 1); c[10] = (f3 == 6);
                c[20] = 1; c[21] = 1;
            end
            'h6F: begin ok = 1; c[11] = 1; c[5] = 1; end
            'h67: begin ok = (f3 == 0); c[12] = 1; c[4] = 1; c[5] = 1; c[20] = 1; end
            'h37: begin ok = 1; c[4] = 1; c[5] = 1; end
            'h73: begin
                if (f3 == 0 && w[31:7] == 0) begin ok = 1; c[17] = 1; end
                else if (f3 == 0 && w[31:20] == 12'h002 && w[19:7] == 0) begin ok = 1; c[18] = 1; end
                else if (f3 == 6) begin ok = 1; c[15] = 1; c[5] = 1; end
                else if (f3 == 7) begin ok = 1; c[16] = 1; c[5] = 1; end
            end
            default: ok = 0;
        endcase
        return ok ? c : 22'h80000;
    endfunction

    // One clock cycle: drive inputs, check every output against the model, advance both.
    task automatic cycle(input bit iv, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                         input bit ordy, input bit fl, input bit ack);
        bit          e_ready, e_push, e_pop;
        logic [21:0] c;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        trap_ack  = ack;
        #1;
        e_ready = !m_lock && !fl && (m_q.size() < DEPTH || ordy);
        check("in_ready",     in_ready,     e_ready);
        check("out_valid",    out_valid,    m_q.size() > 0);
        check("out_instr",    out_instr,    m_q.size() > 0 ? m_q[0].instr : 32'd0);
        check("out_pc",       out_pc,       m_q.size() > 0 ? m_q[0].pc    : 32'd0);
        check("out_ctrl",     out_ctrl,     m_q.size() > 0 ? m_q[0].ctrl  : 22'd0);
        check("count",        count,        m_q.size());
        check("trap_pending", trap_pending, m_lock);
        e_push = iv && e_ready;
        e_pop  = (m_q.size() > 0) && ordy;
        c      = ref_decode(ins);
        @(posedge clk);
        if (e_pop) void'(m_q.pop_front());
        if (e_push) m_q.push_back('{ins, pc, c});
        if (fl) begin
            m_q.delete();
            m_lock = 0;
        end else if (e_push && (c[17] || c[18] || c[19])) begin
            m_lock = 1;
        end else if (ack) begin
            m_lock = 0;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int          sel;
        w   = $urandom;
        sel = $urandom_range(0, 13);
        case (sel)
            0, 1: begin w[6:0] = 7'h33; if ($urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            2, 3: begin w[6:0] = 7'h13; if ($urandom_range(0, 3) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            4:    begin w[6:0] = 7'h03; w[14:12] = 3'($urandom_range(0, 1) * 2); end
            5:    begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
            6:    w[6:0] = 7'h63;
            7:    w[6:0] = 7'h6F;
            8:    begin w[6:0] = 7'h67; w[14:12] = 3'd0; end
            9:    w[6:0] = 7'h37;
            10:   w = 32'h00000073;
            11:   w = 32'h00200073;
            12:   begin w[6:0] = 7'h73; w[14:12] = 3'($urandom_range(6, 7)); end
            default: ; // raw random word
        endcase
        return w;
    endfunction

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0; trap_ack = 0;
        m_lock = 0;
        @(negedge clk); @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_count", count, 0);
        check("rst_ctrl", out_ctrl, 22'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 32'd0, 0, 0, 0, 0);

        // Decode of add, srai, bltu
        cycle(1, 32'h003100B3, 32'h100, 0, 0, 0);
        check("add_ctrl", out_ctrl, 22'h300020);
        cycle(1, 32'h40315093, 32'h104, 1, 0, 0);
        check("srai_ctrl", out_ctrl, 22'h10003D);
        cycle(1, 32'h0020E463, 32'h108, 1, 0, 0);
        check("bltu_ctrl", out_ctrl, 22'h300403);
        cycle(0, 32'd0, 0, 1, 0, 0);

        // Backpressure and full-queue simultaneous push/pop
        cycle(1, 32'h00A00093, 32'h200, 0, 0, 0);
        cycle(1, 32'h00B00113, 32'h204, 0, 0, 0);
        cycle(1, 32'h00C00193, 32'h208, 0, 0, 0);
        check("full_ready", in_ready, 1'b0);
        check("full_count", count, 2);
        cycle(1, 32'h00C00193, 32'h208, 1, 0, 0);
        check("pp_count", count, 2);
        check("pp_head", out_pc, 32'h204);
        cycle(0, 32'd0, 0, 1, 0, 0);
        cycle(0, 32'd0, 0, 1, 0, 0);

        // Trap lock with ecall, then uret
        cycle(1, 32'h00000073, 32'h300, 0, 0, 0);
        check("ecall_ctrl", out_ctrl, 22'h20000);
        check("ecall_lock", trap_pending, 1'b1);
        cycle(1, 32'h003100B3, 32'h304, 0, 0, 0);
        cycle(1, 32'h003100B3, 32'h304, 1, 0, 0);
        cycle(1, 32'h003100B3, 32'h304, 1, 0, 1);
        check("ack_ready", in_ready, 1'b1);
        cycle(1, 32'h003100B3, 32'h304, 0, 0, 0);
        cycle(1, 32'h00200073, 32'h308, 1, 0, 0);
        check("uret_ctrl", out_ctrl, 22'h40000);
        cycle(0, 32'd0, 0, 1, 0, 1);

        // Illegal encodings
        cycle(1, 32'h0000707F, 32'h400, 0, 0, 0);
        check("ill1_ctrl", out_ctrl, 22'h80000);
        check("ill1_lock", trap_pending, 1'b1);
        cycle(0, 32'd0, 0, 1, 0, 1);
        cycle(1, 32'h00001003, 32'h404, 0, 0, 0);
        check("ill2_ctrl", out_ctrl, 22'h80000);
        check("ill2_lock", trap_pending, 1'b1);
        cycle(0, 32'd0, 0, 1, 0, 1);

        // Flush with a full, locked queue
        cycle(1, 32'h003100B3, 32'h500, 0, 0, 0);
        cycle(1, 32'h00000073, 32'h504, 0, 0, 0);
        check("pre_flush_count", count, 2);
        cycle(1, 32'h003100B3, 32'h508, 0, 1, 0);
        check("flush_count", count, 0);
        check("flush_lock", trap_pending, 1'b0);
        check("flush_valid", out_valid, 1'b0);

        // Asynchronous reset in mid-stream
        cycle(1, 32'h003100B3, 32'h600, 0, 0, 0);
        cycle(1, 32'h00B00113, 32'h604, 0, 0, 0);
        in_valid = 0;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_count", count, 0);
        check("arst_lock", trap_pending, 1'b0);
        m_q.delete();
        m_lock = 0;
        @(negedge clk);
        rst = 1'b0;
        cycle(0, 32'd0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, gen_instr(), $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
